branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter DEPTH, default 4, number of in-flight prediction entries; power of two, 2 to 16.
REQ-002 Parameter CNT_W, default 16, width of the statistics counters.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 pred_valid_i  input  1  fetch issued a branch or JAL with a prediction this cycle (push).
REQ-006 pred_pc_i  input  32  PC of the predicted instruction.
REQ-007 pred_taken_i  input  1  predictor said taken.
REQ-008 pred_target_i  input  32  predicted target; meaningful only when pred_taken_i=1.
REQ-009 res_valid_i  input  1  execute resolved the oldest branch or JAL this cycle (pop).
REQ-010 res_pc_i  input  32  PC of the resolved instruction.
REQ-011 res_taken_i  input  1  actual outcome; JAL always 1.
REQ-012 res_target_i  input  32  actual target.
REQ-013 full_o  output  1  queue holds DEPTH entries; fetch shall stall pushes.
REQ-014 redirect_o  output  1  one-cycle pulse requesting a pipeline flush and PC redirect.
REQ-015 redirect_pc_o  output  32  corrected fetch PC, valid with redirect_o.
REQ-016 upd_valid_o  output  1  one-cycle pulse writing the predictor and BTB.
REQ-017 upd_index_o  output  11  predictor and BTB index, equal to res_pc_i[12:2].
REQ-018 upd_taken_o, upd_target_o  output  1, 32  outcome and target for the predictor update.
REQ-019 sync_err_o  output  1  sticky error: resolve with an empty queue, PC mismatch, or overflow.
REQ-020 br_cnt_o, mis_cnt_o  output  CNT_W each  resolved-branch count and mispredict count.

Function
REQ-021 The block SHALL hold a circular FIFO of DEPTH entries {pc, taken, target}, with read pointer, write pointer and an occupancy count of width log2(DEPTH)+1.
REQ-022 A push SHALL occur when pred_valid_i=1, the state is NORMAL, and either the queue is not full or a non-mispredicting pop occurs in the same cycle.
REQ-023 A push while full and not popping SHALL be dropped and SHALL set sync_err_o.
REQ-024 A pop SHALL occur on res_valid_i=1 and SHALL compare the resolved instruction against the head entry.
REQ-025 Mispredict SHALL mean (head.taken != res_taken_i) OR (res_taken_i=1 AND head.target != res_target_i).
REQ-026 If the queue is empty or head.pc != res_pc_i, the block SHALL set sync_err_o, treat the prediction as not-taken, and still evaluate the mispredict condition.
REQ-027 The update outputs SHALL be registered: upd_valid_o=1 exactly one cycle after every res_valid_i, with upd_taken_o=res_taken_i and upd_target_o=res_target_i.
REQ-028 On a mispredict, redirect_o SHALL pulse one cycle after resolve.
REQ-029 With redirect_o, redirect_pc_o SHALL be res_target_i if res_taken_i=1, else res_pc_i+4, using 32-bit wrap-around.
REQ-030 On a mispredict, the queue SHALL be emptied at that same edge: pointers and count to 0, and any same-cycle push discarded.
REQ-031 The FSM SHALL have two states, NORMAL and RECOVER; a mispredict SHALL move NORMAL to RECOVER.
REQ-032 RECOVER SHALL last exactly one cycle, during which pred_valid_i is ignored as wrong-path, and SHALL then return to NORMAL.
REQ-033 br_cnt_o SHALL increment on every pop and mis_cnt_o on every mispredict; both SHALL saturate at all-ones.
REQ-034 A simultaneous push and non-mispredicting pop SHALL leave the count unchanged and advance both pointers.
REQ-035 Pointers SHALL wrap modulo DEPTH.
REQ-036 full_o SHALL be combinational from the count (count==DEPTH); all other outputs SHALL be registered.

Reset
REQ-037 While rst_i=1, regardless of clock: queue empty, state NORMAL, full_o=0, redirect_o=0, redirect_pc_o=0, upd_valid_o=0, upd_index_o=0, upd_taken_o=0, upd_target_o=0, sync_err_o=0, counters 0.
REQ-038 Reset asserted mid-operation SHALL discard all in-flight entries and any pending pulse, which SHALL NOT appear after release.
REQ-039 sync_err_o SHALL clear only by reset.

Verification
REQ-040 Correct prediction: push {0x100, taken, 0x200}; resolve {0x100, taken, 0x200} -> next cycle upd_valid_o=1, upd_index_o=0x040, redirect_o=0, br_cnt_o=1, mis_cnt_o=0.
REQ-041 Direction miss: push {0x104, not taken}; resolve {0x104, taken, 0x300} -> redirect_o=1, redirect_pc_o=0x300, mis_cnt_o=1, queue empty; a push in the following cycle is ignored.
REQ-042 Target miss and fall-through: push {0x108, taken, 0x400}; resolve {0x108, not taken} -> redirect_pc_o=0x10C; pred_pc=0xFFFFFFFC, resolve not taken -> redirect_pc_o=0x0.
REQ-043 Full and overflow (DEPTH=4): four pushes -> full_o=1; a fifth push without a pop -> dropped and sync_err_o=1; push with a correct pop in the same cycle -> count stays 4.
REQ-044 Desync: resolve with an empty queue, taken, target 0x500 -> sync_err_o=1, redirect_o=1, redirect_pc_o=0x500.
REQ-045 Reset mid-flight: three entries queued plus a mispredict resolving in the same cycle as rst_i rises -> no redirect_o pulse, all outputs 0, full_o=0 after release.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues fetch predictions, checks them at resolve,
// drives predictor updates, redirects on mispredict and keeps statistics.
module branch_resolve_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pred_valid_i,
  input  logic [31:0]      pred_pc_i,
  input  logic             pred_taken_i,
  input  logic [31:0]      pred_target_i,
  input  logic             res_valid_i,
  input  logic [31:0]      res_pc_i,
  input  logic             res_taken_i,
  input  logic [31:0]      res_target_i,
  output logic             full_o,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic             upd_valid_o,
  output logic [10:0]      upd_index_o,
  output logic             upd_taken_o,
  output logic [31:0]      upd_target_o,
  output logic             sync_err_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] mis_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  typedef enum logic {NORMAL, RECOVER} state_t;

  state_t          state_q, state_d;
  ent_t            mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            redirect_q;
  logic [31:0]     redirect_pc_q;
  logic            upd_valid_q;
  logic [10:0]     upd_index_q;
  logic            upd_taken_q;
  logic [31:0]     upd_target_q;
  logic            sync_err_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mis_cnt_q;

  ent_t head;
  logic empty;
  logic full;
  logic hit;
  logic pred_tk;
  logic mis;
  logic pop;
  logic push;
  logic overflow;
  logic desync;

  assign head  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign hit   = !empty && (head.pc == res_pc_i);

  // A missing or mismatched head is treated as a not-taken prediction.
  assign pred_tk = hit && head.taken;
  assign mis = res_valid_i &&
               ((pred_tk != res_taken_i) ||
                (res_taken_i && (head.target != res_target_i)));

  assign pop  = res_valid_i && !empty;
  assign push = pred_valid_i && (state_q == NORMAL) && !mis &&
                (!full || pop);

  assign overflow = pred_valid_i && (state_q == NORMAL) &&
                    full && !res_valid_i;
  assign desync   = res_valid_i && !hit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORMAL:  if (mis) state_d = RECOVER;
      RECOVER: state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (mis) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{pc: pred_pc_i,
                           taken: pred_taken_i,
                           target: pred_target_i};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= NORMAL;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      upd_valid_q   <= 1'b0;
      upd_index_q   <= '0;
      upd_taken_q   <= 1'b0;
      upd_target_q  <= '0;
      sync_err_q    <= 1'b0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      redirect_q  <= mis;
      upd_valid_q <= res_valid_i;
      if (mis) begin
        redirect_pc_q <= res_taken_i ? res_target_i
                                     : res_pc_i + 32'd4;
      end
      if (res_valid_i) begin
        upd_index_q  <= res_pc_i[12:2];
        upd_taken_q  <= res_taken_i;
        upd_target_q <= res_target_i;
        if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 1'b1;
      end
      if (mis && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 1'b1;
      if (overflow || desync) sync_err_q <= 1'b1;
    end
  end

  assign full_o        = full;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;
  assign upd_valid_o   = upd_valid_q;
  assign upd_index_o   = upd_index_q;
  assign upd_taken_o   = upd_taken_q;
  assign upd_target_o  = upd_target_q;
  assign sync_err_o    = sync_err_q;
  assign br_cnt_o      = br_cnt_q;
  assign mis_cnt_o     = mis_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: reference queue model feeds a
// per-cycle scoreboard of expected registered outputs.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        pv, pt, rv, rt;
  logic [31:0] ppc, ptg, rpc, rtg;
  logic        full, red, uv, ut, err;
  logic [31:0] rdpc, utg;
  logic [10:0] uidx;
  logic [15:0] brc, misc;

  branch_resolve_unit #(.DEPTH(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .pred_valid_i(pv), .pred_pc_i(ppc),
    .pred_taken_i(pt), .pred_target_i(ptg),
    .res_valid_i(rv), .res_pc_i(rpc),
    .res_taken_i(rt), .res_target_i(rtg),
    .full_o(full), .redirect_o(red), .redirect_pc_o(rdpc),
    .upd_valid_o(uv), .upd_index_o(uidx),
    .upd_taken_o(ut), .upd_target_o(utg),
    .sync_err_o(err), .br_cnt_o(brc), .mis_cnt_o(misc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } ent_t;

  typedef struct packed {
    logic        red;
    logic [31:0] rpc;
    logic        uv;
    logic [10:0] uidx;
    logic        ut;
    logic [31:0] utg;
    logic        err;
    logic [15:0] br;
    logic [15:0] mis;
    logic        full;
  } exp_t;

  int   n_chk = 0;
  int   n_err = 0;
  ent_t m_q[$];
  exp_t sb[$];
  exp_t m;
  logic m_norm;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    sb.delete();
    m = '0;
    m_norm = 1'b1;
  endtask

  task automatic model();
    ent_t h;
    logic empty, hit, ptk, mis, isfull, pop, push;
    empty = (m_q.size() == 0);
    h = empty ? ent_t'(0) : m_q[0];
    hit = !empty && (h.pc == rpc);
    ptk = hit && h.taken;
    mis = rv && ((ptk != rt) || (rt && (h.target != rtg)));
    isfull = (m_q.size() == 4);
    pop = rv && !empty;
    push = pv && m_norm && !mis && (!isfull || pop);
    if (rv && !hit) m.err = 1'b1;
    if (pv && m_norm && isfull && !rv) m.err = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (mis) m_q.delete();
    else if (push) m_q.push_back('{pc: ppc, taken: pt, target: ptg});
    m_norm = !(m_norm && mis);
    m.uv = rv;
    m.red = mis;
    if (rv) begin
      m.uidx = rpc[12:2];
      m.ut = rt;
      m.utg = rtg;
      if (m.br != 16'hFFFF) m.br = m.br + 16'd1;
    end
    if (mis) begin
      m.rpc = rt ? rtg : rpc + 32'd4;
      if (m.mis != 16'hFFFF) m.mis = m.mis + 16'd1;
    end
    m.full = (m_q.size() == 4);
    sb.push_back(m);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_redirect"}, {31'd0, red}, {31'd0, e.red});
    if (e.red) chk({tag, "_rpc"}, rdpc, e.rpc);
    chk({tag, "_upd_valid"}, {31'd0, uv}, {31'd0, e.uv});
    if (e.uv) begin
      chk({tag, "_upd_index"}, {21'd0, uidx}, {21'd0, e.uidx});
      chk({tag, "_upd_taken"}, {31'd0, ut}, {31'd0, e.ut});
      chk({tag, "_upd_target"}, utg, e.utg);
    end
    chk({tag, "_sync_err"}, {31'd0, err}, {31'd0, e.err});
    chk({tag, "_br_cnt"}, {16'd0, brc}, {16'd0, e.br});
    chk({tag, "_mis_cnt"}, {16'd0, misc}, {16'd0, e.mis});
    chk({tag, "_full"}, {31'd0, full}, {31'd0, e.full});
  endtask

  task automatic drive(input logic a, input logic [31:0] b,
                       input logic c, input logic [31:0] d,
                       input logic e, input logic [31:0] f,
                       input logic g, input logic [31:0] h);
    pv = a; ppc = b; pt = c; ptg = d;
    rv = e; rpc = f; rt = g; rtg = h;
  endtask

  task automatic step(input string tag,
                      input logic a, input logic [31:0] b,
                      input logic c, input logic [31:0] d,
                      input logic e, input logic [31:0] f,
                      input logic g, input logic [31:0] h);
    @(negedge clk);
    drive(a, b, c, d, e, f, g, h);
    model();
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_full"}, {31'd0, full}, 32'd0);
    chk({tag, "_redirect"}, {31'd0, red}, 32'd0);
    chk({tag, "_rpc"}, rdpc, 32'd0);
    chk({tag, "_upd_valid"}, {31'd0, uv}, 32'd0);
    chk({tag, "_upd_index"}, {21'd0, uidx}, 32'd0);
    chk({tag, "_upd_taken"}, {31'd0, ut}, 32'd0);
    chk({tag, "_upd_target"}, utg, 32'd0);
    chk({tag, "_sync_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_cnts"}, {brc, misc}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    m_reset();
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    step("ok_push", 1, 32'h100, 1, 32'h200, 0, 0, 0, 0);
    step("ok_res", 0, 0, 0, 0, 1, 32'h100, 1, 32'h200);
    chk("ok_idx", {21'd0, uidx}, 32'h40);

    step("dir_push", 1, 32'h104, 0, 0, 0, 0, 0, 0);
    step("dir_res", 0, 0, 0, 0, 1, 32'h104, 1, 32'h300);
    step("dir_wrong", 1, 32'h900, 1, 32'h904, 0, 0, 0, 0);

    step("tgt_push", 1, 32'h108, 1, 32'h400, 0, 0, 0, 0);
    step("tgt_res", 0, 0, 0, 0, 1, 32'h108, 0, 0);
    idle("tgt_rec");
    step("wrap_push", 1, 32'hFFFFFFFC, 1, 32'h8, 0, 0, 0, 0);
    step("wrap_res", 0, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 0);
    idle("wrap_rec");

    for (int i = 0; i < 300; i++) begin
      logic a, c, e, g;
      logic [31:0] b, d, f, h;
      a = ($urandom_range(0, 2) != 0);
      b = 32'h2000 + 32'($urandom_range(0, 255)) * 4;
      c = $urandom_range(0, 1) == 1;
      d = $urandom_range(0, 1) == 1 ? 32'h200 : 32'h204;
      e = (m_q.size() != 0) && ($urandom_range(0, 1) == 1);
      f = (m_q.size() != 0) ? m_q[0].pc : 32'h0;
      g = (m_q.size() != 0 && $urandom_range(0, 3) != 0)
          ? m_q[0].taken : ($urandom_range(0, 1) == 1);
      h = (m_q.size() != 0 && $urandom_range(0, 3) != 0)
          ? m_q[0].target : d;
      if (m_q.size() == 4 && !e) a = 1'b0;
      step("rand", a, b, c, d, e, f, g, h);
    end
    while (m_q.size() != 0)
      step("drain", 0, 0, 0, 0, 1, m_q[0].pc, m_q[0].taken,
           m_q[0].target);
    idle("drain_idle");

    for (int i = 0; i < 4; i++)
      step("fill", 1, 32'h3000 + 32'(i) * 4, 1, 32'h200, 0, 0, 0, 0);
    chk("full_set", {31'd0, full}, 32'd1);
    step("overflow", 1, 32'h3100, 1, 32'h200, 0, 0, 0, 0);
    step("push_pop_full", 1, 32'h3200, 1, 32'h200,
         1, 32'h3000, 1, 32'h200);
    chk("full_kept", {31'd0, full}, 32'd1);
    while (m_q.size() != 0)
      step("drain2", 0, 0, 0, 0, 1, m_q[0].pc, m_q[0].taken,
           m_q[0].target);

    step("desync", 0, 0, 0, 0, 1, 32'h600, 1, 32'h500);
    chk("desync_rpc", rdpc, 32'h500);
    idle("desync_rec");

    for (int i = 0; i < 3; i++)
      step("pre_rst", 1, 32'h4000 + 32'(i) * 4, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 32'h4000, 1, 32'h700);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    m_reset();
    @(posedge clk);
    #1;
    chk_zero("rst_edge");
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    idle("post_rst");
    step("post_push", 1, 32'h5000, 1, 32'h200, 0, 0, 0, 0);
    step("post_res", 0, 0, 0, 0, 1, 32'h5000, 1, 32'h200);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
